// File: rtl/rtc_pkg.sv
// Shared constants, capture register map and FSM encoding for the RTC A/D bus stage.
package rtc_pkg;

   localparam int ANCHO_DATO = 8;
   localparam int N_REG      = 9;

   localparam int IDX_SEG      = 0;
   localparam int IDX_MIN      = 1;
   localparam int IDX_HORA     = 2;
   localparam int IDX_DIA      = 3;
   localparam int IDX_MES      = 4;
   localparam int IDX_ANIO     = 5;
   localparam int IDX_SEG_TIM  = 6;
   localparam int IDX_MIN_TIM  = 7;
   localparam int IDX_HORA_TIM = 8;

   typedef enum logic [1:0] {
      REPOSO  = 2'd0,
      LECTURA = 2'd1,
      CAPTURA = 2'd2,
      ABORTO  = 2'd3
   } estado_e;

   // True when both nibbles hold a decimal digit.
   function automatic logic esBcd(input logic [ANCHO_DATO-1:0] valor);
      return (valor[7:4] <= 4'd9) && (valor[3:0] <= 4'd9);
   endfunction

endpackage

// File: rtl/rtc_sincronizador.sv
// Multi-flop synchroniser for the asynchronous RTC A/D bus input; ETAPAS sets the depth (2..3).
module rtc_sincronizador #(
   parameter int ANCHO  = rtc_pkg::ANCHO_DATO,
   parameter int ETAPAS = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [ANCHO-1:0] dato_i,
   output logic [ANCHO-1:0] dato_o
);

   logic [ETAPAS-1:0][ANCHO-1:0] etapas_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         etapas_q <= '0;
      end else begin
         etapas_q <= {etapas_q[ETAPAS-2:0], dato_i};
      end
   end

   assign dato_o = etapas_q[ETAPAS-1];

endmodule

// File: rtl/rtc_bus_ad_captura.sv
// RTC A/D bus pin stage: registers controller strobes, drives or releases the bus, and captures read-back bytes.
// Defining RTC_BCD_CHECK_EN rejects captured bytes that are not valid BCD and adds the sticky err_bcd output.
module rtc_bus_ad_captura #(
   parameter int ANCHO_DATO  = rtc_pkg::ANCHO_DATO,
   parameter int N_REG       = rtc_pkg::N_REG,
   parameter int SYNC_ETAPAS = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        a_d_in,
   input  logic                        cs_in,
   input  logic                        rd_in,
   input  logic                        wr_in,
   input  logic                        buffer_activo,
   input  logic [ANCHO_DATO-1:0]       dato_out,
   input  logic [N_REG-1:0]            lect_sel,
   inout  wire  [ANCHO_DATO-1:0]       ad_bus,
   output logic                        a_d_pin,
   output logic                        cs_pin,
   output logic                        rd_pin,
   output logic                        wr_pin,
   output logic [N_REG*ANCHO_DATO-1:0] lect_datos,
   output logic                        captura_ok,
   output logic                        err_sel,
   output logic                        err_conflicto
`ifdef RTC_BCD_CHECK_EN
   ,
   output logic                        err_bcd
`endif
);

   import rtc_pkg::*;

   logic aD_q, cs_q, rd_q, wr_q, csPrev_q, rdPrev_q, buf_q;
   logic [ANCHO_DATO-1:0] datoOut_q, datoSync, muestra_q, muestra_d;
   logic [N_REG-1:0] selLat_q, selLat_d;
   logic [N_REG*ANCHO_DATO-1:0] lect_q, lect_d;
   logic errSel_q, errSel_d, errConf_q, errConf_d, capturaOk_d;
   logic busDrive, csSube, rdSube;
   estado_e state_q, state_d;
`ifdef RTC_BCD_CHECK_EN
   logic errBcd_q, errBcd_d;
`endif

   // Pin strobes idle high and follow the controller with one cycle of latency.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         aD_q      <= 1'b1;
         cs_q      <= 1'b1;
         rd_q      <= 1'b1;
         wr_q      <= 1'b1;
         csPrev_q  <= 1'b1;
         rdPrev_q  <= 1'b1;
         buf_q     <= 1'b0;
         datoOut_q <= '0;
      end else begin
         aD_q      <= a_d_in;
         cs_q      <= cs_in;
         rd_q      <= rd_in;
         wr_q      <= wr_in;
         csPrev_q  <= cs_q;
         rdPrev_q  <= rd_q;
         buf_q     <= buffer_activo;
         datoOut_q <= dato_out;
      end
   end

   assign a_d_pin = aD_q;
   assign cs_pin  = cs_q;
   assign rd_pin  = rd_q;
   assign wr_pin  = wr_q;

   // A read on the pins always wins over our own drive request.
   assign busDrive = buf_q & rd_q;
   assign ad_bus   = busDrive ? datoOut_q : {ANCHO_DATO{1'bz}};
   assign errConf_d = errConf_q | (buf_q & ~rd_q);

   rtc_sincronizador #(
      .ANCHO  (ANCHO_DATO),
      .ETAPAS (SYNC_ETAPAS)
   ) uSinc (
      .clk    (clk),
      .reset  (reset),
      .dato_i (ad_bus),
      .dato_o (datoSync)
   );

   assign csSube = cs_q & ~csPrev_q;
   assign rdSube = rd_q & ~rdPrev_q;

   // State and capture registers; lect_datos shows the write already during CAPTURA.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= REPOSO;
         muestra_q <= '0;
         selLat_q  <= '0;
         lect_q    <= '0;
         errSel_q  <= 1'b0;
         errConf_q <= 1'b0;
`ifdef RTC_BCD_CHECK_EN
         errBcd_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         muestra_q <= muestra_d;
         selLat_q  <= selLat_d;
         lect_q    <= lect_d;
         errSel_q  <= errSel_d;
         errConf_q <= errConf_d;
`ifdef RTC_BCD_CHECK_EN
         errBcd_q  <= errBcd_d;
`endif
      end
   end

   // Read sequencing: sample while rd is low, commit once rd rises, drop the read if cs rises first.
   always_comb begin
      state_d     = state_q;
      muestra_d   = muestra_q;
      selLat_d    = selLat_q;
      lect_d      = lect_q;
      errSel_d    = errSel_q;
      capturaOk_d = 1'b0;
`ifdef RTC_BCD_CHECK_EN
      errBcd_d    = errBcd_q;
`endif
      case (state_q)
         REPOSO: begin
            if (!cs_q && !rd_q) state_d = LECTURA;
         end
         LECTURA: begin
            muestra_d = datoSync;
            selLat_d  = lect_sel;
            if (rdSube) state_d = CAPTURA;
            else if (csSube && !rd_q) state_d = ABORTO;
         end
         CAPTURA: begin
            state_d = REPOSO;
            if (!$onehot(selLat_q)) begin
               errSel_d = 1'b1;
            end
`ifdef RTC_BCD_CHECK_EN
            else if (!esBcd(muestra_q)) begin
               errBcd_d = 1'b1;
            end
`endif
            else begin
               for (int i = 0; i < N_REG; i++) begin
                  if (selLat_q[i]) lect_d[i*ANCHO_DATO +: ANCHO_DATO] = muestra_q;
               end
               capturaOk_d = 1'b1;
            end
         end
         ABORTO: state_d = REPOSO;
         default: state_d = REPOSO;
      endcase
   end

   assign lect_datos    = lect_d;
   assign captura_ok    = capturaOk_d;
   assign err_sel       = errSel_q;
   assign err_conflicto = errConf_q;
`ifdef RTC_BCD_CHECK_EN
   assign err_bcd       = errBcd_q;
`endif

endmodule
